// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - default bit period (clocks per bit) and data-port addresses
//   - bit positions inside the status byte returned to the core
//   - serialiser state type (2-bit encoding)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int         SAMPLE_DEF    = 104;
    localparam logic [8:0] TX_ADDR_DEF   = 9'h101;
    localparam logic [8:0] STAT_ADDR_DEF = 9'h100;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data enqueue strobe and byte (ignored while full)
//   pop             dequeue strobe (ignored while empty)
//   pop_data        head entry, valid whenever empty = 0
//   empty, full     count == 0 / count == DEPTH
//   count           number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign wr_en    = push & ~full;
    assign rd_en    = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers/count, so resetting the contents would only add logic.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter on the core's external data port. Writes to
// TX_ADDR are queued in a byte FIFO and serialised LSB first on o_uart_tx.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_data_wr      one-cycle write strobe from the core
//   i_data_addr    9-bit data address
//   i_data_data    write data
//   o_stat         {5'b0, overflow, full, busy}, combinational from registers
//   o_uart_tx      serial line, idle high
//   o_empty/o_full FIFO status
// Build option: define UART_TX_FIFO_OVF_EN to add the sticky overflow flag
// (set by a write to TX_ADDR while full, cleared by any write to STAT_ADDR).
// Without it o_stat[2] is constant 0 and writes to STAT_ADDR are ignored.
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int         SAMPLE    = SAMPLE_DEF,
    parameter int         DEPTH     = 8,
    parameter logic [8:0] TX_ADDR   = TX_ADDR_DEF,
    parameter logic [8:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_wr,
    input  logic [8:0] i_data_addr,
    input  logic [7:0] i_data_data,
    output logic [7:0] o_stat,
    output logic       o_uart_tx,
    output logic       o_empty,
    output logic       o_full
);

    localparam int            CW       = $clog2(SAMPLE);
    localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE - 1);

    tx_state_e       state, state_next;
    logic [CW-1:0]   smp_cnt, smp_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shift, shift_next;
    logic            line;

    logic            tx_wr;
    logic            fifo_pop;
    logic [7:0]      fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic            busy;
    logic            ovf;

    assign tx_wr = i_data_wr & (i_data_addr == TX_ADDR);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (tx_wr & ~fifo_full),
        .push_data (i_data_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            smp_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            smp_cnt <= smp_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        smp_next   = smp_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        fifo_pop   = 1'b0;
        line       = 1'b1;
        case (state)
            IDLE: begin
                smp_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                line = 1'b0;
                if (smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    state_next = DATA;
                end else begin
                    smp_next = smp_cnt + 1'b1;
                end
            end
            DATA: begin
                line = shift[0];
                if (smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end else begin
                    smp_next = smp_cnt + 1'b1;
                end
            end
            STOP: begin
                if (smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    state_next = IDLE;
                end else begin
                    smp_next = smp_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is decoded from registered state only, so an asynchronous
    // reset forces it high immediately and it never depends on bus inputs.
    assign o_uart_tx = line;

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf <= 1'b0;
        end else if (tx_wr & fifo_full) begin
            ovf <= 1'b1;          // a new overflow beats a same-cycle clear
        end else if (i_data_wr & (i_data_addr == STAT_ADDR)) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    assign busy    = (fifo_count != '0) | (state != IDLE);
    assign o_empty = fifo_empty;
    assign o_full  = fifo_full;

    always_comb begin
        o_stat            = '0;
        o_stat[STAT_BUSY] = busy;
        o_stat[STAT_FULL] = fifo_full;
        o_stat[STAT_OVF]  = ovf;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo at SAMPLE=4, DEPTH=8. A queue-based model tracks the
// FIFO and the frame in flight (position within a 10*SAMPLE-clock frame) and
// predicts every output each cycle; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int         S     = 4;
    localparam int         D     = 8;
    localparam logic [8:0] TX    = 9'h101;
    localparam logic [8:0] STAT  = 9'h100;
    localparam logic [8:0] OTHER = 9'h102;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [8:0] addr = '0;
    logic [7:0] data = '0;
    logic [7:0] o_stat;
    logic       o_uart_tx;
    logic       o_empty;
    logic       o_full;

    uart_tx_fifo #(.SAMPLE(S), .DEPTH(D), .TX_ADDR(TX), .STAT_ADDR(STAT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_wr   (wr),
        .i_data_addr (addr),
        .i_data_data (data),
        .o_stat      (o_stat),
        .o_uart_tx   (o_uart_tx),
        .o_empty     (o_empty),
        .o_full      (o_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = '0;
    bit         m_ovf    = 1'b0;

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        int  pre;
        bit  do_push, ovf_set, ovf_clr;
        pre     = q.size();
        do_push = wr && addr == TX && pre < D;
        ovf_set = wr && addr == TX && pre == D;
        ovf_clr = wr && addr == STAT;
        if (m_active) begin
            m_pos++;
            if (m_pos == 10*S) m_active = 1'b0;
        end else if (pre > 0) begin
            m_cur    = q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (do_push) q.push_back(data);
`ifdef UART_TX_FIFO_OVF_EN
        if (ovf_set)      m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
`else
        if (ovf_set || ovf_clr) m_ovf = 1'b0;
`endif
    endtask

    function automatic logic exp_line();
        if (!m_active)       return 1'b1;
        if (m_pos < S)       return 1'b0;
        if (m_pos < 9*S)     return m_cur[(m_pos - S) / S];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic busy_e, full_e;
        @(negedge clk);
        full_e = (q.size() == D);
        busy_e = (q.size() != 0) || m_active;
        check("line",  o_uart_tx, exp_line());
        check("empty", o_empty,   q.size() == 0);
        check("full",  o_full,    full_e);
        check("stat",  o_stat,    {5'b0, m_ovf, full_e, busy_e});
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [8:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; data = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    logic [0:43] a5_line = 44'b1_0000_1111_0000_1111_0000_0000_1111_0000_1111_1111_111;
    logic [0:43] a5_busy = {{41{1'b1}}, 3'b000};

    initial begin
        int k0;
        idle(3);
        rst = 1'b0;
        check("reset_line",  o_uart_tx, 1'b1);
        check("reset_empty", o_empty,   1'b1);
        check("reset_full",  o_full,    1'b0);
        check("reset_stat",  o_stat,    8'h00);

        // Single 8'hA5 frame, literal line and busy sequence.
        do_write(TX, 8'hA5);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            check($sformatf("a5_line[%0d]", i), o_uart_tx, a5_line[i]);
            check($sformatf("a5_busy[%0d]", i), o_stat[0], a5_busy[i]);
        end
        idle(2);

        // One frame in flight, then 9 back-to-back writes: 8 fill, 9th dropped.
        do_write(TX, 8'h00);
        k0 = cyc;
        for (int i = 0; i < 9; i++) begin
            do_write(TX, 8'(8'h31 + i));
            if (i == 7) begin
                @(negedge clk);
                check("full_after_8", o_full, 1'b1);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", o_stat[2], 1'b1);
`else
        check("ovf_off", o_stat[2], 1'b0);
`endif
        check("full_hold", o_full, 1'b1);
        @(posedge clk); #1;
        do_write(STAT, 8'h00);
        @(negedge clk);
        check("ovf_clear", o_stat[2], 1'b0);
        for (int j = 1; j <= 8; j++) begin
            wait_cyc(k0 + 41*j);
            check($sformatf("gap_%0d", j), o_uart_tx, 1'b1);
            wait_cyc(k0 + 41*j + 1);
            check($sformatf("start_%0d", j), o_uart_tx, 1'b0);
        end
        idle(45);

        // Push while popping with three entries queued: count stays 3.
        do_write(TX, 8'h01);
        k0 = cyc;
        do_write(TX, 8'h02);
        do_write(TX, 8'h03);
        do_write(TX, 8'h04);
        while (cyc < k0 + 41) @(posedge clk);
        #1;
        do_write(TX, 8'h05);
        @(negedge clk);
        check("pp_empty", o_empty, 1'b0);
        check("pp_full",  o_full,  1'b0);
        idle(4*41 + 5);

        // Reset during DATA bit 3 with more bytes queued.
        do_write(TX, 8'h3C);
        k0 = cyc;
        do_write(TX, 8'h11);
        do_write(TX, 8'h22);
        wait_cyc(k0 + 18);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_line",  o_uart_tx, 1'b1);
        check("mid_rst_empty", o_empty,   1'b1);
        check("mid_rst_stat",  o_stat,    8'h00);
        idle(2);
        rst = 1'b0;
        do_write(TX, 8'h96);
        idle(45);

        // Other address and read-only cycles change nothing.
        do_write(OTHER, 8'h55);
        @(negedge clk);
        check("other_empty", o_empty, 1'b1);
        check("other_stat",  o_stat,  8'h00);
        addr = TX; data = 8'hEE;
        idle(1);
        @(negedge clk);
        check("read_empty", o_empty, 1'b1);
        @(posedge clk); #1;

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                wr  = 1'b0;
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else begin
                int sel;
                sel  = $urandom_range(0, 9);
                wr   = ($urandom_range(0, 5) == 0);
                addr = (sel < 7) ? TX : (sel < 9) ? STAT : OTHER;
                data = 8'($urandom);
                idle(1);
            end
        end
        wr = 1'b0;

        // Drain, bounded.
        for (int i = 0; i < 1000 && (q.size() != 0 || m_active); i++) idle(1);
        @(negedge clk);
        check("drain_busy", o_stat[0], 1'b0);
        check("drain_line", o_uart_tx, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
